// File: rtl/vga_capture_decim_pkg.sv
// Shared VGA 640x480 timing, x5 decimation geometry and capture state encoding.
package vga_capture_decim_pkg;
  localparam int H_ACTIVE       = 640;
  localparam int V_ACTIVE       = 480;
  localparam int DECIM          = 5;
  localparam int OUT_W          = H_ACTIVE / DECIM;   // 128
  localparam int OUT_H          = V_ACTIVE / DECIM;   // 96
  localparam int FRAME_WRITES   = OUT_W * OUT_H;
  localparam int ADDR_W         = 14;

  localparam int H_SYNC_W       = 96;
  localparam int H_BACK_PORCH   = 48;
  localparam int H_FRONT_PORCH  = 16;
  localparam int V_SYNC_W       = 2;
  localparam int V_BACK_PORCH   = 33;
  localparam int V_FRONT_PORCH  = 10;

  localparam int H_ACT_START_DEF = H_SYNC_W + H_BACK_PORCH;
  localparam int V_ACT_START_DEF = V_SYNC_W + V_BACK_PORCH;
  localparam int H_TOTAL_DEF     = H_ACT_START_DEF + H_ACTIVE + H_FRONT_PORCH;
  localparam int V_TOTAL_DEF     = V_ACT_START_DEF + V_ACTIVE + V_FRONT_PORCH;

  typedef enum logic [1:0] {ST_UNLOCKED, ST_LOCKED, ST_CAPTURE, ST_DONE} cap_state_e;

  function automatic logic [2:0] sub_inc(input logic [2:0] s);
    return (s == 3'(DECIM - 1)) ? 3'd0 : s + 3'd1;
  endfunction
endpackage

// File: rtl/vga_capture_decim_if.sv
// Video-in / frame-buffer-write bundle; slave is the capture block.
interface vga_capture_decim_if;
  import vga_capture_decim_pkg::*;
  logic              pix_en;
  logic              hsync;
  logic              vsync;
  logic [2:0]        rgb_in;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [2:0]        wr_data;
  logic              frame_done;
  logic              sync_err;

  modport master (output pix_en, hsync, vsync, rgb_in,
                  input  wr_en, wr_addr, wr_data, frame_done, sync_err);
  modport slave  (input  pix_en, hsync, vsync, rgb_in,
                  output wr_en, wr_addr, wr_data, frame_done, sync_err);
endinterface

// File: rtl/vga_capture_decim_sync_edge_det.sv
// Falling-edge pulse for one sync line, qualified by pix_en against the last sampled level.
module sync_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic sync,
  output logic fall
);
  logic hist;

  always_ff @(posedge clk) begin
    if (!reset)  hist <= 1'b1;
    else if (en) hist <= sync;
  end

  assign fall = en & hist & ~sync;
endmodule

// File: rtl/vga_capture_decim.sv
// Captures a 640x480 VGA stream and writes the top-left pixel of each 5x5 block (128x96).
module vga_capture_decim
  import vga_capture_decim_pkg::*;
#(
  parameter int H_ACT_START = H_ACT_START_DEF,
  parameter int V_ACT_START = V_ACT_START_DEF,
  parameter int H_TOTAL     = H_TOTAL_DEF,
  parameter int V_TOTAL     = V_TOTAL_DEF
) (
  input logic               clk,
  input logic               reset,
  vga_capture_decim_if.slave bus
);
  localparam int H_ACT_END = H_ACT_START + H_ACTIVE;
  localparam int V_ACT_END = V_ACT_START + V_ACTIVE;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WRITES - 1);

  cap_state_e        state, state_nxt;
  logic [9:0]        h_cnt, v_cnt, h_nxt, v_nxt;
  logic [2:0]        h_sub, v_sub;
  logic [1:0]        sync_s, fall;
  logic              h_fall, v_fall, active, keep, line_end, last_wr;
  logic              wr_en_r, sync_err_r;
  logic [ADDR_W-1:0] wr_addr_r;
  logic [2:0]        wr_data_r;

  assign sync_s = {bus.vsync, bus.hsync};
  for (genvar i = 0; i < 2; i++) begin : g_edge
    sync_edge_det u_det (.clk(clk), .reset(reset), .en(bus.pix_en), .sync(sync_s[i]), .fall(fall[i]));
  end
  assign h_fall = fall[0];
  assign v_fall = fall[1];

  // Counters after this sample: the sample on the hsync edge is pixel 0.
  always_comb begin
    h_nxt = h_cnt;
    v_nxt = v_cnt;
    if (h_fall)                          h_nxt = '0;
    else if (h_cnt != 10'(H_TOTAL - 1))  h_nxt = h_cnt + 10'd1;
    if (v_fall)      v_nxt = '0;
    else if (h_fall) v_nxt = v_cnt + 10'd1;
  end

  assign active   = bus.pix_en && (h_nxt >= 10'(H_ACT_START)) && (h_nxt < 10'(H_ACT_END))
                                && (v_nxt >= 10'(V_ACT_START)) && (v_nxt < 10'(V_ACT_END));
  assign line_end = active && (h_nxt == 10'(H_ACT_END - 1));
  assign keep     = active && !v_fall && (state == ST_CAPTURE) && (h_sub == '0) && (v_sub == '0);
  assign last_wr  = wr_en_r && (wr_addr_r == LAST_ADDR);

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_UNLOCKED;
    else        state <= state_nxt;
  end

  // Any vsync edge re-arms the frame; a short/long frame is only flagged once locked.
  always_comb begin
    state_nxt = state;
    if (v_fall) state_nxt = ST_LOCKED;
    else begin
      case (state)
        ST_UNLOCKED: state_nxt = ST_UNLOCKED;
        ST_LOCKED:   if (bus.pix_en && v_cnt == 10'(V_ACT_START)) state_nxt = ST_CAPTURE;
        ST_CAPTURE:  if (last_wr) state_nxt = ST_DONE;
        ST_DONE:     state_nxt = ST_LOCKED;
        default:     state_nxt = ST_UNLOCKED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      h_cnt      <= '0;
      v_cnt      <= '0;
      h_sub      <= '0;
      v_sub      <= '0;
      wr_en_r    <= 1'b0;
      wr_addr_r  <= '0;
      wr_data_r  <= '0;
      sync_err_r <= 1'b0;
    end else begin
      wr_en_r <= keep;
      if (bus.pix_en) begin
        h_cnt     <= h_nxt;
        v_cnt     <= v_nxt;
        wr_data_r <= bus.rgb_in;
        if (h_fall || v_fall) h_sub <= '0;
        else if (active)      h_sub <= sub_inc(h_sub);
        if (v_fall)           v_sub <= '0;
        else if (line_end)    v_sub <= sub_inc(v_sub);
      end
      if (v_fall && state != ST_UNLOCKED && v_cnt != 10'(V_TOTAL - 1)) sync_err_r <= 1'b1;
      if (v_fall)       wr_addr_r <= '0;
      else if (wr_en_r) wr_addr_r <= (wr_addr_r == LAST_ADDR) ? '0 : wr_addr_r + 1'b1;
    end
  end

  assign bus.wr_en      = wr_en_r;
  assign bus.wr_addr    = wr_addr_r;
  assign bus.wr_data    = wr_data_r;
  assign bus.frame_done = (state == ST_DONE);
  assign bus.sync_err   = sync_err_r;
endmodule

// File: tb/tb_vga_capture_decim.sv
// Directed bench: drives full VGA lines and checks every output cycle against a pixel-position model.
module tb_vga_capture_decim;
  logic clk = 1'b0;
  logic reset;
  vga_capture_decim_if bus();

  vga_capture_decim dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  bit mlock, fd_pend;
  int n_wr, n_fd, n_bad, bad_h, bad_v;
  int fw_h, fw_v, fw_addr, d127, d128;

  task automatic clr_stats();
    n_wr = 0; n_fd = 0; n_bad = 0; bad_h = -1; bad_v = -1;
    fw_h = -1; fw_v = -1; fw_addr = -1; d127 = -1; d128 = -1;
  endtask

  // One clock: present pixel (h,v), then compare outputs against the expected keep/address/data.
  task automatic px(input int h, input int v, input bit pe);
    bit kept, exp_fd, ok;
    int ea;
    if (pe && h == 0 && v == 0) mlock = 1'b1;
    kept = pe && mlock && v >= 35 && v < 515 && (v - 35) % 5 == 0
              && h >= 144 && h < 784 && (h - 144) % 5 == 0;
    ea = ((v - 35) / 5) * 128 + (h - 144) / 5;
    bus.pix_en = pe;
    bus.hsync  = (h >= 96);
    bus.vsync  = (v >= 2);
    bus.rgb_in = 3'((h + v) % 8);
    @(posedge clk); #1;
    exp_fd  = fd_pend;
    fd_pend = kept && ea == 12287;
    ok = (bus.wr_en === kept) && (bus.frame_done === exp_fd);
    if (kept) ok = ok && (bus.wr_addr === 14'(ea)) && (bus.wr_data === 3'((h + v) % 8));
    if (bus.wr_en === 1'b1) begin
      n_wr++;
      if (fw_h < 0) begin fw_h = h; fw_v = v; fw_addr = int'(bus.wr_addr); end
      if (bus.wr_addr == 14'd127 && d127 < 0) d127 = int'(bus.wr_data);
      if (bus.wr_addr == 14'd128 && d128 < 0) d128 = int'(bus.wr_data);
    end
    if (bus.frame_done === 1'b1) n_fd++;
    if (!ok) begin
      n_bad++;
      if (bad_h < 0) begin bad_h = h; bad_v = v; end
    end
  endtask

  task automatic run_lines(input int v0, input int n, input int per);
    int v;
    for (int l = 0; l < n; l++) begin
      v = (v0 + l) % 525;
      for (int h = 0; h < 800; h++) begin
        px(h, v, 1'b1);
        for (int k = 1; k < per; k++) px(h, v, 1'b0);
      end
    end
  endtask

  task automatic test_reset();
    bus.pix_en = 1'b0; bus.hsync = 1'b1; bus.vsync = 1'b1; bus.rgb_in = 3'd0;
    reset = 1'b0; mlock = 1'b0; fd_pend = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++; if (bus.wr_en !== 1'b0) $display("FAIL reset_wr_en got=%b want=0", bus.wr_en); else pass_cnt++;
    total_cnt++; if (bus.wr_addr !== 14'd0) $display("FAIL reset_wr_addr got=%0d want=0", bus.wr_addr); else pass_cnt++;
    total_cnt++; if (bus.wr_data !== 3'd0) $display("FAIL reset_wr_data got=%0d want=0", bus.wr_data); else pass_cnt++;
    total_cnt++; if (bus.frame_done !== 1'b0) $display("FAIL reset_frame_done got=%b want=0", bus.frame_done); else pass_cnt++;
    total_cnt++; if (bus.sync_err !== 1'b0) $display("FAIL reset_sync_err got=%b want=0", bus.sync_err); else pass_cnt++;
    reset = 1'b1;
  endtask

  task automatic test_mid_frame_start();
    clr_stats();
    run_lines(480, 45, 1);
    total_cnt++; if (n_wr !== 0) $display("FAIL midstart_writes got=%0d want=0", n_wr); else pass_cnt++;
    total_cnt++; if (n_bad !== 0) $display("FAIL midstart_stream got=%0d bad cycles (first h=%0d v=%0d) want=0", n_bad, bad_h, bad_v); else pass_cnt++;
    total_cnt++; if (bus.sync_err !== 1'b0) $display("FAIL midstart_sync_err got=%b want=0", bus.sync_err); else pass_cnt++;
  endtask

  task automatic test_clean_frame();
    clr_stats();
    run_lines(0, 525, 1);
    total_cnt++; if (n_bad !== 0) $display("FAIL clean_stream got=%0d bad cycles (first h=%0d v=%0d) want=0", n_bad, bad_h, bad_v); else pass_cnt++;
    total_cnt++; if (n_wr !== 12288) $display("FAIL clean_writes got=%0d want=12288", n_wr); else pass_cnt++;
    total_cnt++; if (n_fd !== 1) $display("FAIL clean_frame_done got=%0d want=1", n_fd); else pass_cnt++;
    total_cnt++; if (fw_h !== 144) $display("FAIL clean_first_h got=%0d want=144", fw_h); else pass_cnt++;
    total_cnt++; if (fw_v !== 35) $display("FAIL clean_first_v got=%0d want=35", fw_v); else pass_cnt++;
    total_cnt++; if (fw_addr !== 0) $display("FAIL clean_first_addr got=%0d want=0", fw_addr); else pass_cnt++;
    total_cnt++; if (d127 !== 6) $display("FAIL clean_addr127_data got=%0d want=6", d127); else pass_cnt++;
    total_cnt++; if (d128 !== 0) $display("FAIL clean_addr128_data got=%0d want=0", d128); else pass_cnt++;
    total_cnt++; if (bus.sync_err !== 1'b0) $display("FAIL clean_sync_err got=%b want=0", bus.sync_err); else pass_cnt++;
  endtask

  // Next frame's first pixel carries both sync edges after a 525-line frame.
  task automatic test_coincident();
    clr_stats();
    run_lines(0, 2, 1);
    total_cnt++; if (bus.sync_err !== 1'b0) $display("FAIL coincident_sync_err got=%b want=0", bus.sync_err); else pass_cnt++;
    total_cnt++; if (n_bad !== 0) $display("FAIL coincident_stream got=%0d bad cycles want=0", n_bad); else pass_cnt++;
  endtask

  task automatic test_sparse_pix_en();
    clr_stats();
    run_lines(2, 33, 1);
    run_lines(35, 15, 4);
    total_cnt++; if (n_bad !== 0) $display("FAIL sparse_stream got=%0d bad cycles (first h=%0d v=%0d) want=0", n_bad, bad_h, bad_v); else pass_cnt++;
    total_cnt++; if (n_wr !== 384) $display("FAIL sparse_writes got=%0d want=384", n_wr); else pass_cnt++;
    total_cnt++; if (fw_h !== 144 || fw_v !== 35) $display("FAIL sparse_first_pos got=%0d,%0d want=144,35", fw_h, fw_v); else pass_cnt++;
    total_cnt++; if (fw_addr !== 0) $display("FAIL sparse_first_addr got=%0d want=0", fw_addr); else pass_cnt++;
    total_cnt++; if (d127 !== 6) $display("FAIL sparse_addr127_data got=%0d want=6", d127); else pass_cnt++;
    total_cnt++; if (d128 !== 0) $display("FAIL sparse_addr128_data got=%0d want=0", d128); else pass_cnt++;
    total_cnt++; if (n_fd !== 0) $display("FAIL sparse_frame_done got=%0d want=0", n_fd); else pass_cnt++;
  endtask

  task automatic test_sync_err();
    clr_stats();
    run_lines(50, 250, 1);
    total_cnt++; if (bus.sync_err !== 1'b0) $display("FAIL syncerr_before got=%b want=0", bus.sync_err); else pass_cnt++;
    total_cnt++; if (n_fd !== 0) $display("FAIL syncerr_aborted_frame_done got=%0d want=0", n_fd); else pass_cnt++;
    clr_stats();
    px(0, 0, 1'b1);
    total_cnt++; if (bus.sync_err !== 1'b1) $display("FAIL syncerr_set got=%b want=1", bus.sync_err); else pass_cnt++;
    for (int h = 1; h < 800; h++) px(h, 0, 1'b1);
    run_lines(1, 524, 1);
    total_cnt++; if (n_fd !== 1) $display("FAIL syncerr_frame_done got=%0d want=1", n_fd); else pass_cnt++;
    total_cnt++; if (n_wr !== 12288) $display("FAIL syncerr_writes got=%0d want=12288", n_wr); else pass_cnt++;
    total_cnt++; if (n_bad !== 0) $display("FAIL syncerr_stream got=%0d bad cycles (first h=%0d v=%0d) want=0", n_bad, bad_h, bad_v); else pass_cnt++;
    total_cnt++; if (fw_addr !== 0) $display("FAIL syncerr_first_addr got=%0d want=0", fw_addr); else pass_cnt++;
    total_cnt++; if (bus.sync_err !== 1'b1) $display("FAIL syncerr_sticky got=%b want=1", bus.sync_err); else pass_cnt++;
  endtask

  task automatic test_midframe_reset();
    clr_stats();
    run_lines(0, 200, 1);
    total_cnt++; if (n_bad !== 0) $display("FAIL rst_prefix_stream got=%0d bad cycles want=0", n_bad); else pass_cnt++;
    reset = 1'b0; mlock = 1'b0; fd_pend = 1'b0;
    px(0, 200, 1'b1);
    reset = 1'b1;
    total_cnt++; if (bus.wr_en !== 1'b0) $display("FAIL rst_wr_en got=%b want=0", bus.wr_en); else pass_cnt++;
    total_cnt++; if (bus.wr_addr !== 14'd0) $display("FAIL rst_wr_addr got=%0d want=0", bus.wr_addr); else pass_cnt++;
    total_cnt++; if (bus.wr_data !== 3'd0) $display("FAIL rst_wr_data got=%0d want=0", bus.wr_data); else pass_cnt++;
    total_cnt++; if (bus.frame_done !== 1'b0) $display("FAIL rst_frame_done got=%b want=0", bus.frame_done); else pass_cnt++;
    total_cnt++; if (bus.sync_err !== 1'b0) $display("FAIL rst_sync_err got=%b want=0", bus.sync_err); else pass_cnt++;
    clr_stats();
    run_lines(500, 25, 1);
    total_cnt++; if (n_wr !== 0) $display("FAIL rst_unlocked_writes got=%0d want=0", n_wr); else pass_cnt++;
    clr_stats();
    run_lines(0, 41, 1);
    total_cnt++; if (n_wr !== 256) $display("FAIL rst_relock_writes got=%0d want=256", n_wr); else pass_cnt++;
    total_cnt++; if (fw_h !== 144 || fw_v !== 35) $display("FAIL rst_first_pos got=%0d,%0d want=144,35", fw_h, fw_v); else pass_cnt++;
    total_cnt++; if (fw_addr !== 0) $display("FAIL rst_first_addr got=%0d want=0", fw_addr); else pass_cnt++;
    total_cnt++; if (n_bad !== 0) $display("FAIL rst_relock_stream got=%0d bad cycles (first h=%0d v=%0d) want=0", n_bad, bad_h, bad_v); else pass_cnt++;
    total_cnt++; if (bus.sync_err !== 1'b0) $display("FAIL rst_relock_sync_err got=%b want=0", bus.sync_err); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_mid_frame_start();
    test_clean_frame();
    test_coincident();
    test_sparse_pix_en();
    test_sync_err();
    test_midframe_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/vga_capture_decim.md
VGA_CAPTURE_DECIM -- requirements
Module: vga_capture_decim

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- H_ACT_START 144: pixel index of the first active pixel, counted from the HSYNC falling edge.
- V_ACT_START 35: line index of the first active line, counted from the VSYNC falling edge.
- H_TOTAL 800: pixels per line.
- V_TOTAL 525: lines per frame.
REQ-002 clk  input  1  system clock; all logic is on its rising edge.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 pix_en  input  1  pixel strobe; one pixel is present per cycle in which pix_en=1.
REQ-005 hsync  input  1  active-low horizontal sync, synchronous to clk.
REQ-006 vsync  input  1  active-low vertical sync, synchronous to clk.
REQ-007 rgb_in  input  3  pixel colour {R,G,B}.
REQ-008 wr_en  output  1  frame-buffer write strobe.
REQ-009 wr_addr  output  14  frame-buffer address, row*128+col.
REQ-010 wr_data  output  3  pixel to store.
REQ-011 frame_done  output  1  one-cycle pulse after the last write of a frame.
REQ-012 sync_err  output  1  sticky flag for a frame-length violation.

Function
REQ-013 The block captures a 640x480 stream and stores the top-left pixel of every 5x5 block, giving 128x96 = 12288 writes per frame; it is the write-side counterpart of the x5 display replicator.
REQ-014 hsync, vsync and rgb_in are sampled only in pix_en cycles; a falling edge is a sample of 0 whose previous pix_en sample was 1.
REQ-015 h_cnt (10 bit): cleared to 0 on an hsync falling edge, otherwise +1 per pix_en, saturating at H_TOTAL-1.
REQ-016 v_cnt (10 bit): cleared to 0 on a vsync falling edge, otherwise +1 per hsync falling edge.
REQ-017 Active pixel window: H_ACT_START <= h_cnt < H_ACT_START+640 and V_ACT_START <= v_cnt < V_ACT_START+480.
REQ-018 h_sub and v_sub (3 bit each) count 0..4 and wrap to 0.
- h_sub advances per active pixel and is cleared at the start of each line.
- v_sub advances at the end of each active line and is cleared on a vsync falling edge.
REQ-019 Decimation:
- An active pixel with h_sub=0 and v_sub=0 is kept.
- wr_en=1 in the cycle after the pix_en cycle that sampled the kept pixel.
- wr_data is the registered rgb_in; wr_en is otherwise 0.
REQ-020 wr_addr is 0 for the first write of a frame and increments by 1 after each write, reaching 12287 on the last write.
REQ-021 State machine:
- UNLOCKED to LOCKED on a vsync falling edge.
- LOCKED to CAPTURE when v_cnt=V_ACT_START.
- CAPTURE to DONE after the write at address 12287.
- DONE to LOCKED in the next cycle, with frame_done=1 for that one cycle.
REQ-022 Writes occur only in CAPTURE.
REQ-023 A vsync falling edge with v_cnt != V_TOTAL-1, while in any state other than UNLOCKED:
- sets sync_err;
- aborts any frame in progress without a frame_done pulse;
- restarts the frame (v_cnt=0, state LOCKED, wr_addr=0).
REQ-024 A vsync edge and an hsync edge in the same pix_en cycle: the vsync edge wins and v_cnt=0.
REQ-025 pix_en=0 holds every counter and the state; wr_en, when already scheduled, still fires in the following cycle.

Reset
REQ-026 On reset=0 at a rising clk edge, the following take effect on that edge:
- state=UNLOCKED;
- h_cnt, v_cnt, h_sub, v_sub and wr_addr = 0;
- wr_en=0, wr_data=0, frame_done=0, sync_err=0;
- edge-detect history = 1 (idle high).
REQ-027 A reset in mid-frame discards the partial frame; capture resumes only after the next vsync falling edge plus V_ACT_START lines.

Structure
REQ-028 A shared package holds:
- the timing constants (640, 480, 128, 96, decimation factor 5, H_TOTAL, V_TOTAL, sync/porch widths);
- the state encoding.
REQ-029 One sub-module, sync_edge_det, produces the registered falling-edge pulses for hsync and vsync.

Verification
REQ-030 Clean frame, pix_en=1 every cycle, rgb_in = (h_cnt+v_cnt) mod 8 -> exactly 12288 wr_en pulses; first write at addr 0 carries the pixel at h_cnt=144, v_cnt=35; addr 127 carries h_cnt=779; addr 128 carries v_cnt=40; one frame_done after addr 12287.
REQ-031 pix_en=1 every 4th cycle -> same 12288 writes and data as REQ-030; each wr_en exactly 1 cycle after its pix_en.
REQ-032 Second vsync after 300 lines -> sync_err=1, no frame_done, next frame starts again at addr 0 and completes 12288 writes.
REQ-033 reset=0 for 1 cycle at line 200 -> all outputs 0 the next cycle; no write until a vsync edge plus 35 lines.
REQ-034 Coincident hsync and vsync falling edges -> v_cnt=0 and no sync_err when the previous frame had 525 lines.
REQ-035 Stream started mid-frame (no vsync yet) -> zero writes until the first vsync falling edge.
